// File: rtl/btn_rst_conditioner.sv
// -----------------------------------------------------------------------------
// btn_rst_conditioner
//   Board-input conditioner for the FPGA top level. Each of NUM_BTN raw
//   buttons/switches is passed through a two-flop synchroniser and a
//   counter-based debouncer. The result is a clean level per channel plus
//   one-cycle press and release pulses. The block also builds a stretched,
//   registered platform reset from RST_IN and from the debounced level of
//   channel RST_BTN_IDX.
//
//   Optional feature macro: LONG_PRESS_EN
//     defined   : per-channel hold counters; BTN_LONG_OUT pulses once per hold,
//                 LONG_PRESS_CYCLES cycles after the level rises.
//     undefined : no hold counters; BTN_LONG_OUT is constant 0.
//
// Ports
//   CLK_IN          in   1        system clock, rising edge
//   RST_IN          in   1        asynchronous active-high reset
//   BTN_IN          in   NUM_BTN  raw asynchronous inputs, active-high
//   BTN_LEVEL_OUT   out  NUM_BTN  debounced stable level
//   BTN_PRESS_OUT   out  NUM_BTN  one-cycle pulse on a stable 0->1
//   BTN_RELEASE_OUT out  NUM_BTN  one-cycle pulse on a stable 1->0
//   BTN_LONG_OUT    out  NUM_BTN  one-cycle long-press pulse
//   RST_OUT         out  1        registered active-high platform reset
// -----------------------------------------------------------------------------
module btn_rst_conditioner #(
  parameter int unsigned NUM_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned CNT_W             = 5,
  parameter int unsigned RST_BTN_IDX       = 0,
  parameter int unsigned RST_STRETCH       = 8,
  parameter int unsigned LONG_PRESS_CYCLES = 64
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_LEVEL_OUT,
  output logic [NUM_BTN-1:0] BTN_PRESS_OUT,
  output logic [NUM_BTN-1:0] BTN_RELEASE_OUT,
  output logic [NUM_BTN-1:0] BTN_LONG_OUT,
  output logic               RST_OUT
);

  localparam int unsigned STR_W = 8;

  // Elaboration-time range check of the configuration.
  localparam bit PARAMS_OK = (NUM_BTN >= 1) && (NUM_BTN <= 16) &&
                             (CNT_W >= 1) && (CNT_W <= 16) &&
                             (DEBOUNCE_CYCLES >= 1) &&
                             (DEBOUNCE_CYCLES <= (32'd1 << CNT_W)) &&
                             (RST_BTN_IDX < NUM_BTN) &&
                             (RST_STRETCH >= 1) && (RST_STRETCH <= 255) &&
                             (LONG_PRESS_CYCLES >= 1);

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("btn_rst_conditioner: parameter out of range");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, nothing between the stages.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= BTN_IN;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] release_q;
  logic [NUM_BTN-1:0] release_d;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // Pulses are registered together with the level, so they land in
          // the same cycle the level changes.
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign BTN_LEVEL_OUT   = level_q;
  assign BTN_PRESS_OUT   = press_q;
  assign BTN_RELEASE_OUT = release_q;

  // ---------------------------------------------------------------------------
  // Long-press detector.
  // ---------------------------------------------------------------------------
`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  logic [HOLD_W-1:0]  hold_q [NUM_BTN];
  logic [HOLD_W-1:0]  hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_q;
  logic [NUM_BTN-1:0] long_d;

  // Counter saturates at LONG_PRESS_CYCLES so each hold yields one pulse.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      hold_d[i] = '0;
      if (level_q[i]) begin
        if (hold_q[i] != HOLD_W'(LONG_PRESS_CYCLES)) begin
          hold_d[i] = hold_q[i] + HOLD_W'(1);
        end else begin
          hold_d[i] = hold_q[i];
        end
        long_d[i] = (hold_q[i] == HOLD_W'(LONG_PRESS_CYCLES - 1));
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        hold_q[i] <= '0;
      end
      long_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        hold_q[i] <= hold_d[i];
      end
      long_q <= long_d;
    end
  end

  assign BTN_LONG_OUT = long_q;
`else
  assign BTN_LONG_OUT = '0;
`endif

  // ---------------------------------------------------------------------------
  // Reset stretcher. RST_IN holds the counter at RST_STRETCH through the async
  // clear; the reset button reloads it every cycle its level is high.
  // RST_OUT is the registered "counter non-zero after this edge", so it rises
  // one cycle after the button level and falls on the RST_STRETCH-th edge
  // after both sources are released.
  // ---------------------------------------------------------------------------
  logic [STR_W-1:0] stretch_q;
  logic [STR_W-1:0] stretch_d;
  logic             rst_out_q;
  logic             rst_out_d;

  always_comb begin
    stretch_d = stretch_q;
    if (level_q[RST_BTN_IDX]) begin
      stretch_d = STR_W'(RST_STRETCH);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - STR_W'(1);
    end
    rst_out_d = (stretch_d != '0);
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      stretch_q <= STR_W'(RST_STRETCH);
      rst_out_q <= 1'b1;
    end else begin
      stretch_q <= stretch_d;
      rst_out_q <= rst_out_d;
    end
  end

  assign RST_OUT = rst_out_q;

endmodule

// File: tb/tb_btn_rst_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_rst_conditioner
//   Directed bench. Stimulus pushes the expected output word and the cycle at
//   which it must appear; the monitor pops one entry each time the DUT output
//   word changes and checks both value and cycle.
//   Output word = {RST_OUT, LONG[3:0], RELEASE[3:0], PRESS[3:0], LEVEL[3:0]}.
// -----------------------------------------------------------------------------
module tb_btn_rst_conditioner;

  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          rst_in;
  logic [NB-1:0] btn;
  logic [NB-1:0] level;
  logic [NB-1:0] press;
  logic [NB-1:0] rel;
  logic [NB-1:0] lng;
  logic          rst_out;

  btn_rst_conditioner #(
    .NUM_BTN          (NB),
    .DEBOUNCE_CYCLES  (4),
    .CNT_W            (5),
    .RST_BTN_IDX      (0),
    .RST_STRETCH      (8),
    .LONG_PRESS_CYCLES(64)
  ) dut (
    .CLK_IN         (clk),
    .RST_IN         (rst_in),
    .BTN_IN         (btn),
    .BTN_LEVEL_OUT  (level),
    .BTN_PRESS_OUT  (press),
    .BTN_RELEASE_OUT(rel),
    .BTN_LONG_OUT   (lng),
    .RST_OUT        (rst_out)
  );

  always #5 clk = ~clk;

  // Edge counter: at the falling edge after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [16:0] val;
    int          id;
  } exp_t;

  exp_t sbq[$];
  int   n_id   = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  logic [16:0] outs;
  logic [16:0] prev = '1;
  assign outs = {rst_out, lng, rel, press, level};

  function automatic logic [16:0] vv(input logic r, input logic [3:0] lg,
                                     input logic [3:0] rl, input logic [3:0] pr,
                                     input logic [3:0] lv);
    return {r, lg, rl, pr, lv};
  endfunction

  task automatic expect_at(input int off, input logic [16:0] v);
    exp_t e;
    e.cyc = cyc + off;
    e.val = v;
    e.id  = n_id;
    n_id++;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: every change of the output word must match the next expectation.
  always @(negedge clk) begin
    if (outs != prev) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%05h want=no-change", cyc, outs);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        n_vec++;
        if (e.cyc != cyc || e.val != outs) begin
          n_err++;
          $display("FAIL ev%0d got cyc=%0d val=%05h want cyc=%0d val=%05h",
                   e.id, cyc, outs, e.cyc, e.val);
        end
      end
      prev = outs;
    end
  end

  bit bounce [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    // 1. Power-on: reset state, then RST_OUT falls on the 8th edge after release.
    rst_in = 1'b1;
    btn    = '0;
    expect_at(1, vv(1, 4'h0, 4'h0, 4'h0, 4'h0));
    step(3);
    rst_in = 1'b0;
    expect_at(8, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    step(12);

    // 2. Clean press and release on channel 2.
    btn = 4'b0100;
    expect_at(6, vv(0, 4'h0, 4'h0, 4'h4, 4'h4));
    expect_at(7, vv(0, 4'h0, 4'h0, 4'h0, 4'h4));
    step(12);
    btn = 4'b0000;
    expect_at(6, vv(0, 4'h0, 4'h4, 4'h0, 4'h0));
    expect_at(7, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    step(12);

    // 3. Bounce on channel 1: only the run of four 1s after the 0 counts.
    expect_at(10, vv(0, 4'h0, 4'h0, 4'h2, 4'h2));
    expect_at(11, vv(0, 4'h0, 4'h0, 4'h0, 4'h2));
    for (int i = 0; i < 8; i++) begin
      btn[1] = bounce[i];
      step(1);
    end
    step(6);
    btn[1] = 1'b0;
    expect_at(6, vv(0, 4'h0, 4'h2, 4'h0, 4'h0));
    expect_at(7, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    step(12);

    // 4. Button reset on channel 0, re-press while the stretch is running.
    expect_at(6,  vv(0, 4'h0, 4'h0, 4'h1, 4'h1));
    expect_at(7,  vv(1, 4'h0, 4'h0, 4'h0, 4'h1));
    expect_at(26, vv(1, 4'h0, 4'h1, 4'h0, 4'h0));
    expect_at(27, vv(1, 4'h0, 4'h0, 4'h0, 4'h0));
    expect_at(30, vv(1, 4'h0, 4'h0, 4'h1, 4'h1));
    expect_at(31, vv(1, 4'h0, 4'h0, 4'h0, 4'h1));
    expect_at(46, vv(1, 4'h0, 4'h1, 4'h0, 4'h0));
    expect_at(47, vv(1, 4'h0, 4'h0, 4'h0, 4'h0));
    expect_at(54, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    btn[0] = 1'b1;
    step(20);
    btn[0] = 1'b0;
    step(4);   // shortest gap that still lets the level fall
    btn[0] = 1'b1;
    step(16);
    btn[0] = 1'b0;
    step(20);

    // 5a. All channels pressed on the same edge.
    expect_at(6,  vv(0, 4'h0, 4'h0, 4'hF, 4'hF));
    expect_at(7,  vv(1, 4'h0, 4'h0, 4'h0, 4'hF));
    expect_at(16, vv(1, 4'h0, 4'hF, 4'h0, 4'h0));
    expect_at(17, vv(1, 4'h0, 4'h0, 4'h0, 4'h0));
    expect_at(24, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    btn = 4'b1111;
    step(10);
    btn = 4'b0000;
    step(20);

    // 5b. RST_IN pulse mid-debounce of channel 3 restarts the count.
    expect_at(4,  vv(1, 4'h0, 4'h0, 4'h0, 4'h0));
    expect_at(11, vv(1, 4'h0, 4'h0, 4'h8, 4'h8));
    expect_at(12, vv(1, 4'h0, 4'h0, 4'h0, 4'h8));
    expect_at(13, vv(0, 4'h0, 4'h0, 4'h0, 4'h8));
    btn[3] = 1'b1;
    step(3);
    rst_in = 1'b1;
    step(2);
    rst_in = 1'b0;
    step(10);
    btn[3] = 1'b0;
    expect_at(6, vv(0, 4'h0, 4'h8, 4'h0, 4'h0));
    expect_at(7, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    step(12);

    // 6. 100-cycle hold on channel 3: one long pulse 64 cycles after the rise.
    expect_at(6, vv(0, 4'h0, 4'h0, 4'h8, 4'h8));
    expect_at(7, vv(0, 4'h0, 4'h0, 4'h0, 4'h8));
`ifdef LONG_PRESS_EN
    expect_at(70, vv(0, 4'h8, 4'h0, 4'h0, 4'h8));
    expect_at(71, vv(0, 4'h0, 4'h0, 4'h0, 4'h8));
`endif
    expect_at(106, vv(0, 4'h0, 4'h8, 4'h0, 4'h0));
    expect_at(107, vv(0, 4'h0, 4'h0, 4'h0, 4'h0));
    btn[3] = 1'b1;
    step(100);
    btn[3] = 1'b0;
    step(15);

    // Any expectation still queued never appeared on the outputs.
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL ev%0d missing want cyc=%0d val=%05h got=none", e.id, e.cyc, e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
